// File: rtl/mod_add_pkg.sv
// mod_add_pkg: shared widths and modular-add helpers for the mod-add datapaths
package mod_add_pkg;
  localparam int DEFAULT_BITWIDTH = 16;
  // Helpers work at a fixed wide width so any BITWIDTH up to MAX_W-1 keeps its carry bit.
  localparam int MAX_W = 64;
  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction
  // One conditional subtraction: exact for a, b < q; the caller truncates to its width.
  function automatic logic [MAX_W-1:0] mod_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                               input logic [MAX_W-1:0] q);
    logic [MAX_W-1:0] s;
    s = a + b;
    return (s >= q) ? s - q : s;
  endfunction
endpackage

// File: rtl/mod_add_core.sv
// mod_add_core: combinational (a + b) mod q with a single conditional subtraction
//   iA, iB  operands
//   iQ      modulus (0 gives the truncated sum)
//   oSum    reduced sum
module mod_add_core
  import mod_add_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iB,
  input  logic [BITWIDTH-1:0] iQ,
  output logic [BITWIDTH-1:0] oSum
);
  assign oSum = BITWIDTH'(mod_add(MAX_W'(iA), MAX_W'(iB), MAX_W'(iQ)));
endmodule

// File: rtl/mod_add_arbiter.sv
// mod_add_arbiter: round-robin sharing of one registered modular adder among NUM_REQ requesters
//   iClk, iRst (async, high), iClr (sync clear)
//   iQ                          shared modulus, sampled on acceptance
//   iReqValid/oReqReady         per-requester handshake, operands on iReqData0/iReqData1
//   oRspValid/iRspReady         result handshake, oRspId owner index, oRspData modular sum
//   oGrantCnt                   per-requester saturating grant counts (MOD_ADD_ARB_STATS_EN only)
module mod_add_arbiter
  import mod_add_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iClr,
  input  logic [BITWIDTH-1:0]         iQ,
  input  logic [NUM_REQ-1:0]          iReqValid,
  input  logic [NUM_REQ*BITWIDTH-1:0] iReqData0,
  input  logic [NUM_REQ*BITWIDTH-1:0] iReqData1,
  output logic [NUM_REQ-1:0]          oReqReady,
  output logic                        oRspValid,
  output logic [ID_W-1:0]             oRspId,
  output logic [BITWIDTH-1:0]         oRspData,
`ifdef MOD_ADD_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]       oGrantCnt,
`endif
  input  logic                        iRspReady
);
  logic [ID_W-1:0] ptr, grantId, nextPtr;
  logic [NUM_REQ-1:0] grant;
  logic found, slotFree, accept;
  logic [BITWIDTH-1:0] sum;
  int idx;
  // First valid requester scanning from ptr upward, wrapping at NUM_REQ.
  always_comb begin
    grant = '0;
    grantId = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && iReqValid[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        grantId = ID_W'(idx);
      end
    end
  end
  assign slotFree = ~oRspValid | iRspReady;
  assign oReqReady = (slotFree && !iClr) ? grant : '0;
  assign accept = |oReqReady;
  assign nextPtr = (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
  mod_add_core #(.BITWIDTH(BITWIDTH)) u_core (
    .iA  (iReqData0[grantId*BITWIDTH +: BITWIDTH]),
    .iB  (iReqData1[grantId*BITWIDTH +: BITWIDTH]),
    .iQ  (iQ),
    .oSum(sum)
  );
  always_ff @(posedge iClk or posedge iRst)
    if (iRst || iClr) begin
      ptr <= '0;
      oRspValid <= 1'b0;
      oRspId <= '0;
      oRspData <= '0;
    end else if (accept) begin
      ptr <= nextPtr;
      oRspValid <= 1'b1;
      oRspId <= grantId;
      oRspData <= sum;
    end else if (iRspReady) oRspValid <= 1'b0;
`ifdef MOD_ADD_ARB_STATS_EN
  logic [15:0] grantCnt [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    always_ff @(posedge iClk or posedge iRst)
      if (iRst || iClr) grantCnt[i] <= '0;
      else if (oReqReady[i] && grantCnt[i] != 16'hFFFF) grantCnt[i] <= grantCnt[i] + 16'd1;
    assign oGrantCnt[i*16 +: 16] = grantCnt[i];
  end
`endif
endmodule

// File: doc/mod_add_arbiter.md
# mod_add_arbiter

Round-robin arbiter and sequencer that shares one registered modular adder, computing (a + b) mod q, among NUM_REQ independent requesters. Each requester presents an operand pair under a valid/ready handshake. The winner's operands are reduced against the shared modulus iQ and returned one cycle later, tagged with the requester index, under a second valid/ready handshake. The block sits between the NTT/polynomial-arithmetic front-ends and the single modular-addition datapath.

## Interface
- BITWIDTH, 16: operand, modulus and result width
- NUM_REQ, 4: number of requesters (≥2); ID_W = $clog2(NUM_REQ)
- iClk  in  1  clock, all state on rising edge
- iRst  in  1  asynchronous, active-high reset
- iClr  in  1  synchronous clear: same effect as reset, applied at the edge
- iQ  in  BITWIDTH  shared modulus, sampled on the acceptance cycle
- iReqValid  in  NUM_REQ  per-requester request valid
- iReqData0  in  NUM_REQ*BITWIDTH  operand a, requester i at bits [i*BITWIDTH +: BITWIDTH]
- iReqData1  in  NUM_REQ*BITWIDTH  operand b, same packing
- oReqReady  out  NUM_REQ  one-hot-or-zero grant; request i is accepted when iReqValid[i] & oReqReady[i]
- oRspValid  out  1  result valid
- oRspId  out  ID_W  index of the requester that owns the result
- oRspData  out  BITWIDTH  modular sum
- iRspReady  in  1  consumer accepts the result when oRspValid & iRspReady

## Operation
- Round-robin pointer ptr (ID_W bits) holds the highest-priority index. The grant goes to the first i with iReqValid[i], scanning ptr, ptr+1, … modulo NUM_REQ.
- oReqReady[i] = grant[i] & slot_free, where slot_free = ~oRspValid | iRspReady. oReqReady is combinational from iReqValid, ptr, oRspValid and iRspReady.
- On acceptance of requester g:
  - ptr ← (g+1) mod NUM_REQ
  - oRspData ← result
  - oRspId ← g
  - oRspValid ← 1
- ptr does not move without an acceptance.
- Response drained with no new acceptance: oRspValid ← 0. oRspData and oRspId hold their last values.
- Result arithmetic:
  - s = a + b computed at BITWIDTH+1 bits.
  - result = (s ≥ {1'b0,iQ}) ? s − iQ : s, truncated to BITWIDTH.
  - Exact when a, b < iQ. Operands ≥ iQ get one conditional subtraction only, with no further correction.
  - iQ = 0 yields the truncated sum.
- A requester may drop iReqValid before acceptance. No request is latched until accepted.
- iReqData and iQ must be stable only in the acceptance cycle.

## Timing
- Latency: request accepted at edge t → oRspValid high after edge t.
- Throughput: one accept per cycle while iRspReady = 1.
- Back-pressure: while oRspValid & ~iRspReady, all oReqReady = 0. oRspValid, oRspId and oRspData hold stable.
- Simultaneous drain and accept in the same cycle is allowed. The new result replaces the old one with no bubble.
- Reset/clear values: oRspValid = 0, oRspData = 0, oRspId = 0, ptr = 0, statistics counters = 0.
- Reset or clear while a response is pending discards it. The first grant after reset scans from index 0.
- iClr has priority over any acceptance in the same cycle. No oReqReady is asserted while iClr = 1.

## Configuration
- MOD_ADD_ARB_STATS_EN defined:
  - Adds output oGrantCnt, NUM_REQ*16 bits, packed like iReqData0.
  - oGrantCnt holds one saturating 16-bit count per requester, incremented on each acceptance of that requester.
  - Counters are cleared by iRst or iClr and stick at 16'hFFFF.
- Not defined: port and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Package mod_add_pkg:
  - default BITWIDTH
  - function id_width(n) returning $clog2(n)
  - function mod_add(a, b, q) implementing the reduction rule above
- Sub-module mod_add_core: purely combinational, operands and modulus in, reduced sum out. It wraps pkg::mod_add and is reused by other datapaths.
- The top level holds the round-robin grant logic, ptr, the response register and the optional counters.

## Test plan
- Single request: iQ = 23, requester 0 with a = 10, b = 20, iRspReady = 1 → next cycle oRspValid = 1, oRspId = 0, oRspData = 7.
- Sweep iQ 23…32 with a = 10, b = 20 → results 7, 6, 5, 4, 3, 2, 1, 0, 30, 30.
- Carry bit: iQ = 65521, a = b = 65520 → oRspData = 65519.
- Fairness: all four iReqValid held high with distinct operands, iRspReady = 1 → oRspId sequence 0, 1, 2, 3, 0, 1 on consecutive cycles.
- Back-pressure: iRspReady = 0 for 3 cycles with a response pending → oRspData/oRspId stable, oReqReady = 0. When iRspReady returns to 1, the next grant follows the saved ptr.
- Reset/clear: assert iRst, then separately iClr, with oRspValid = 1 and ptr = 2 → outputs zero, next grant from index 0. With MOD_ADD_ARB_STATS_EN, all oGrantCnt = 0.
